pll_lock_supervisor: RTL and testbench

Parametrised lock supervisor and reset sequencer for the ECP5 EHXPLLL clock generators (SDRAM, camera, video PLLs).
- Drives the PLL RST pin and watches the PLL LOCK output.
- Once lock has been stable, releases NUM_CH downstream domain resets in a fixed staggered order.
- Recovers automatically from lock loss and lock timeout, and keeps saturating event counters for debug.
- Runs on the 25 MHz board reference clock, not on a PLL output.

---
 rtl/pll_lock_supervisor_if.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and domain-side signals of the lock supervisor.
// The supervisor connects through the slave modport. The environment
// (PLL model or testbench) connects through the master modport.
interface pll_lock_supervisor_if #(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 8
);
   logic              pll_locked;
   logic              restart_req;
   logic              pll_rst;
   logic [NUM_CH-1:0] domain_rst_n;
   logic              ready;
   logic [CNT_W-1:0]  lock_loss_cnt;
   logic [CNT_W-1:0]  timeout_cnt;
   logic [2:0]        state_o;

   modport slave (
      input  pll_locked, restart_req,
      output pll_rst, domain_rst_n, ready, lock_loss_cnt, timeout_cnt, state_o
   );

   modport master (
      output pll_locked, restart_req,
      input  pll_rst, domain_rst_n, ready, lock_loss_cnt, timeout_cnt, state_o
   );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor and staggered domain reset sequencer.
// Runs on the board reference clock so it keeps working while the PLL is unlocked.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst asserted for RST_PULSE_CYCLES, all domains held
// WAIT_LOCK | waiting for synchronised lock, times out after TIMEOUT_CYCLES
// STABLE    | counting consecutive lock cycles up to STABLE_CYCLES
// RELEASE   | releasing domain resets one by one, STAGGER_CYCLES apart
// RUN       | all domains released, ready asserted
module pll_lock_supervisor #(
   parameter int NUM_CH           = 3,
   parameter int STABLE_CYCLES    = 1024,
   parameter int STAGGER_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES   = 65536,
   parameter int RST_PULSE_CYCLES = 8,
   parameter int CNT_W            = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pll_lock_supervisor_if.slave  bus
);
   // One shared timer serves every state. It must hold the largest terminal value.
   localparam int M_A   = (TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES;
   localparam int M_B   = (STAGGER_CYCLES > RST_PULSE_CYCLES) ? STAGGER_CYCLES : RST_PULSE_CYCLES;
   localparam int T_MAX = (M_A > M_B) ? M_A : M_B;
   localparam int TMR_W = $clog2(T_MAX);
   localparam int CH_W  = $clog2(NUM_CH + 1);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RELEASE   = 3'd3,
      S_RUN       = 3'd4
   } state_t;

   state_t            r_state, w_state_nx;
   logic [TMR_W-1:0]  r_tmr, w_tmr_nx;
   logic [CH_W-1:0]   r_ch, w_ch_nx;
   logic [NUM_CH-1:0] r_dom, w_dom_nx;
   logic [CNT_W-1:0]  r_lcnt, w_lcnt_nx;
   logic [CNT_W-1:0]  r_tcnt, w_tcnt_nx;
   logic [1:0]        r_sync;
   logic              w_lk;

   assign w_lk = r_sync[1];

   // State register, timer, release vector, event counters and lock synchroniser.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_RESET_PLL;
         r_tmr   <= '0;
         r_ch    <= '0;
         r_dom   <= '0;
         r_lcnt  <= '0;
         r_tcnt  <= '0;
         r_sync  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_tmr   <= w_tmr_nx;
         r_ch    <= w_ch_nx;
         r_dom   <= w_dom_nx;
         r_lcnt  <= w_lcnt_nx;
         r_tcnt  <= w_tcnt_nx;
         r_sync  <= {r_sync[0], bus.pll_locked};
      end
   end

   // Next-state logic. restart_req overrides everything, including counter updates.
   // r_ch holds the index of the next domain to release.
   always_comb begin
      w_state_nx = r_state;
      w_tmr_nx   = r_tmr;
      w_ch_nx    = r_ch;
      w_dom_nx   = r_dom;
      w_lcnt_nx  = r_lcnt;
      w_tcnt_nx  = r_tcnt;
      if (bus.restart_req) begin
         w_state_nx = S_RESET_PLL;
         w_tmr_nx   = '0;
         w_ch_nx    = '0;
         w_dom_nx   = '0;
      end else begin
         case (r_state)
            S_RESET_PLL: begin
               w_dom_nx = '0;
               if (r_tmr == TMR_W'(RST_PULSE_CYCLES - 1)) begin
                  w_state_nx = S_WAIT_LOCK;
                  w_tmr_nx   = '0;
               end else begin
                  w_tmr_nx = r_tmr + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (w_lk) begin
                  w_state_nx = S_STABLE;
                  w_tmr_nx   = '0;
               end else if (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  w_state_nx = S_RESET_PLL;
                  w_tmr_nx   = '0;
                  if (r_tcnt != '1) w_tcnt_nx = r_tcnt + 1'b1;
               end else begin
                  w_tmr_nx = r_tmr + 1'b1;
               end
            end
            S_STABLE: begin
               if (!w_lk) begin
                  w_state_nx = S_WAIT_LOCK;
                  w_tmr_nx   = '0;
               end else if (r_tmr == TMR_W'(STABLE_CYCLES - 1)) begin
                  w_state_nx  = S_RELEASE;
                  w_tmr_nx    = '0;
                  w_dom_nx    = '0;
                  w_dom_nx[0] = 1'b1;
                  w_ch_nx     = CH_W'(1);
               end else begin
                  w_tmr_nx = r_tmr + 1'b1;
               end
            end
            S_RELEASE, S_RUN: begin
               if (!w_lk) begin
                  w_state_nx = S_WAIT_LOCK;
                  w_tmr_nx   = '0;
                  w_ch_nx    = '0;
                  w_dom_nx   = '0;
                  if (r_lcnt != '1) w_lcnt_nx = r_lcnt + 1'b1;
               end else if (r_state == S_RELEASE) begin
                  if (r_tmr == TMR_W'(STAGGER_CYCLES - 1)) begin
                     w_tmr_nx = '0;
                     if (r_ch == CH_W'(NUM_CH)) begin
                        w_state_nx = S_RUN;
                     end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                           if (r_ch == CH_W'(i)) w_dom_nx[i] = 1'b1;
                        end
                        w_ch_nx = r_ch + 1'b1;
                     end
                  end else begin
                     w_tmr_nx = r_tmr + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nx = S_RESET_PLL;
               w_tmr_nx   = '0;
               w_ch_nx    = '0;
               w_dom_nx   = '0;
            end
         endcase
      end
   end

   assign bus.pll_rst       = (r_state == S_RESET_PLL);
   assign bus.ready         = (r_state == S_RUN);
   assign bus.domain_rst_n  = r_dom;
   assign bus.lock_loss_cnt = r_lcnt;
   assign bus.timeout_cnt   = r_tcnt;
   assign bus.state_o       = r_state;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor using the small test configuration.
module tb_pll_lock_supervisor;
   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   hi, lo, k;
   logic pr_seen;

   pll_lock_supervisor_if #(.NUM_CH(3), .CNT_W(4)) bus ();

   pll_lock_supervisor #(
      .NUM_CH(3), .STABLE_CYCLES(8), .STAGGER_CYCLES(4),
      .TIMEOUT_CYCLES(32), .RST_PULSE_CYCLES(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, 32'(bus.state_o), 0);
      chk({tag, "_pll_rst"}, 32'(bus.pll_rst), 1);
      chk({tag, "_dom"}, 32'(bus.domain_rst_n), 0);
      chk({tag, "_ready"}, 32'(bus.ready), 0);
      chk({tag, "_lcnt"}, 32'(bus.lock_loss_cnt), 0);
      chk({tag, "_tcnt"}, 32'(bus.timeout_cnt), 0);
   endtask

   // Counts samples with pll_rst high, starting at the current sample.
   task automatic measure_pulse(output int width);
      width = 0;
      while (bus.pll_rst === 1'b1 && width < 100) begin
         tick();
         width++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.pll_locked  = 1'b0;
      bus.restart_req = 1'b0;
      repeat (5) tick();
      chk_reset_vals("reset");

      // Clean power-up
      rst_n = 1'b1;
      measure_pulse(hi);
      chk("pwrup_pll_rst_width", hi, 4);
      chk("pwrup_state_wait", 32'(bus.state_o), 1);
      repeat (10) tick();
      bus.pll_locked = 1'b1;
      repeat (3) tick();
      chk("pwrup_state_stable", 32'(bus.state_o), 2);
      repeat (7) tick();
      chk("pwrup_dom_before", 32'(bus.domain_rst_n), 0);
      tick();
      chk("pwrup_dom0", 32'(bus.domain_rst_n), 3'b001);
      chk("pwrup_state_release", 32'(bus.state_o), 3);
      repeat (3) tick();
      chk("pwrup_dom1_before", 32'(bus.domain_rst_n), 3'b001);
      tick();
      chk("pwrup_dom1", 32'(bus.domain_rst_n), 3'b011);
      repeat (3) tick();
      chk("pwrup_dom2_before", 32'(bus.domain_rst_n), 3'b011);
      tick();
      chk("pwrup_dom2", 32'(bus.domain_rst_n), 3'b111);
      repeat (3) tick();
      chk("pwrup_ready_before", 32'(bus.ready), 0);
      tick();
      chk("pwrup_ready", 32'(bus.ready), 1);
      chk("pwrup_state_run", 32'(bus.state_o), 4);
      chk("pwrup_run_pll_rst", 32'(bus.pll_rst), 0);

      // Soft restart coinciding with a lock drop
      bus.restart_req = 1'b1;
      bus.pll_locked  = 1'b0;
      tick();
      bus.restart_req = 1'b0;
      chk("restart_state", 32'(bus.state_o), 0);
      chk("restart_pll_rst", 32'(bus.pll_rst), 1);
      chk("restart_dom", 32'(bus.domain_rst_n), 0);
      chk("restart_ready", 32'(bus.ready), 0);
      measure_pulse(hi);
      chk("restart_pll_rst_width", hi, 4);
      chk("restart_lcnt", 32'(bus.lock_loss_cnt), 0);

      // Lock glitch during STABLE
      bus.pll_locked = 1'b1;
      repeat (5) tick();
      bus.pll_locked = 1'b0;
      tick();
      bus.pll_locked = 1'b1;
      repeat (2) tick();
      chk("glitch_back_to_wait", 32'(bus.state_o), 1);
      repeat (8) tick();
      chk("glitch_dom_held", 32'(bus.domain_rst_n), 0);
      tick();
      chk("glitch_dom0", 32'(bus.domain_rst_n), 3'b001);
      chk("glitch_lcnt", 32'(bus.lock_loss_cnt), 0);
      repeat (12) tick();
      chk("glitch_ready", 32'(bus.ready), 1);

      // Lock loss in RUN
      bus.pll_locked = 1'b0;
      pr_seen = 1'b0;
      repeat (3) begin tick(); pr_seen |= bus.pll_rst; end
      chk("loss_dom", 32'(bus.domain_rst_n), 0);
      chk("loss_ready", 32'(bus.ready), 0);
      chk("loss_state", 32'(bus.state_o), 1);
      chk("loss_lcnt", 32'(bus.lock_loss_cnt), 1);
      repeat (17) begin tick(); pr_seen |= bus.pll_rst; end
      chk("loss_no_pll_rst", 32'(pr_seen), 0);
      bus.pll_locked = 1'b1;
      repeat (10) tick();
      chk("loss_dom_held", 32'(bus.domain_rst_n), 0);
      tick();
      chk("loss_dom0_again", 32'(bus.domain_rst_n), 3'b001);
      repeat (12) tick();
      chk("loss_ready_again", 32'(bus.ready), 1);
      chk("loss_dom_all_again", 32'(bus.domain_rst_n), 3'b111);

      // Timeouts with lock held low
      bus.pll_locked = 1'b0;
      k = 0;
      while (bus.pll_rst !== 1'b1 && k < 100) begin tick(); k++; end
      chk("timeout_first_rise", k, 35);
      chk("timeout_lcnt", 32'(bus.lock_loss_cnt), 2);
      for (int n = 1; n <= 16; n++) begin
         chk("timeout_cnt", 32'(bus.timeout_cnt), (n > 15) ? 15 : n);
         measure_pulse(hi);
         lo = 0;
         while (bus.pll_rst !== 1'b1 && lo < 100) begin tick(); lo++; end
         chk("timeout_pulse_width", hi, 4);
         chk("timeout_period", hi + lo, 36);
      end
      chk("timeout_saturated", 32'(bus.timeout_cnt), 15);

      // Reset in the middle of RELEASE
      bus.pll_locked = 1'b1;
      k = 0;
      while (bus.domain_rst_n[0] !== 1'b1 && k < 100) begin tick(); k++; end
      chk("midrel_dom0_delay", k, 13);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("midrel");
      rst_n = 1'b1;
      measure_pulse(hi);
      chk("midrel_pll_rst_width", hi, 4);
      repeat (8) tick();
      chk("midrel_dom_held", 32'(bus.domain_rst_n), 0);
      tick();
      chk("midrel_dom0", 32'(bus.domain_rst_n), 3'b001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
